// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multiply / restoring divide sequencer built around one shared
// add-with-carry-in / B-invert ALU; one iteration per clock, single-cycle done pulse.

module muldiv_alu #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             nb,
   output logic [WIDTH-1:0] s
);
   logic [WIDTH-1:0] bx_s;

   // optional B inversion followed by the modulo-2^WIDTH add
   always_comb begin
      if (nb) begin
         bx_s = ~b;
      end else begin
         bx_s = b;
      end
      s = a + bx_s + {{(WIDTH-1){1'b0}}, ci};
   end
endmodule

module muldiv_seq #(
   parameter int WIDTH = 16,
   parameter int ITER  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             div_by_zero
);
   localparam int CNT_W = $clog2(ITER);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_r, state_s;
   logic              busy_s, done_s;
   logic              accept_s, dbz_s;
   logic              op_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [WIDTH-1:0]  hi_r, lo_r, opnd_r;
   logic [WIDTH-1:0]  hi_nxt_s, lo_nxt_s;
   logic [WIDTH:0]    r17_s;
   logic [WIDTH-1:0]  alu_a_s, alu_b_s, alu_s;
   logic              alu_ci_s, alu_nb_s, carry_s, b15_s;

   // The ALU has no carry-out, so recover it from the MSBs of its operands and sum.
   function automatic logic alu_carry(input logic a15, input logic b15, input logic s15);
      return (a15 & b15) | ((a15 | b15) & ~s15);
   endfunction

   muldiv_alu #(.WIDTH(WIDTH)) u_alu (
      .a  (alu_a_s),
      .b  (alu_b_s),
      .ci (alu_ci_s),
      .nb (alu_nb_s),
      .s  (alu_s)
   );

   assign accept_s = start & ((state_r == IDLE) | (state_r == DONE));
   assign dbz_s    = accept_s & op & (b == {WIDTH{1'b0}});

   // state register with registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_r <= state_s;
         busy    <= busy_s;
         done    <= done_s;
      end
   end

   // next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE, DONE: begin
            if (dbz_s) begin
               state_s = DONE;
            end else if (accept_s) begin
               state_s = RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (cnt_r == CNT_W'(ITER - 1)) begin
               state_s = DONE;
            end else begin
               state_s = RUN;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // status outputs follow the state being entered
   always_comb begin
      busy_s = 1'b0;
      done_s = 1'b0;
      case (state_s)
         RUN:     busy_s = 1'b1;
         DONE:    done_s = 1'b1;
         default: begin
            busy_s = 1'b0;
            done_s = 1'b0;
         end
      endcase
   end

   // ALU operand steering for one shift-add or restoring-divide step
   always_comb begin
      r17_s    = {hi_r, lo_r[WIDTH-1]};
      alu_a_s  = hi_r;
      alu_b_s  = {WIDTH{1'b0}};
      alu_ci_s = 1'b0;
      alu_nb_s = 1'b0;
      if (op_r) begin
         alu_a_s  = r17_s[WIDTH-1:0];
         alu_b_s  = opnd_r;
         alu_ci_s = 1'b1;
         alu_nb_s = 1'b1;
      end else if (lo_r[0]) begin
         alu_b_s = opnd_r;
      end else begin
         alu_b_s = {WIDTH{1'b0}};
      end
   end

   // working-register update for the current step
   always_comb begin
      if (alu_nb_s) begin
         b15_s = ~alu_b_s[WIDTH-1];
      end else begin
         b15_s = alu_b_s[WIDTH-1];
      end
      carry_s = alu_carry(alu_a_s[WIDTH-1], b15_s, alu_s[WIDTH-1]);
      if (!op_r) begin
         hi_nxt_s = {carry_s, alu_s[WIDTH-1:1]};
         lo_nxt_s = {alu_s[0], lo_r[WIDTH-1:1]};
      end else if (r17_s[WIDTH] | carry_s) begin
         hi_nxt_s = alu_s;
         lo_nxt_s = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
         hi_nxt_s = r17_s[WIDTH-1:0];
         lo_nxt_s = {lo_r[WIDTH-2:0], 1'b0};
      end
   end

   // operand capture, iteration and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r        <= 1'b0;
         cnt_r       <= {CNT_W{1'b0}};
         hi_r        <= {WIDTH{1'b0}};
         lo_r        <= {WIDTH{1'b0}};
         opnd_r      <= {WIDTH{1'b0}};
         result_lo   <= {WIDTH{1'b0}};
         result_hi   <= {WIDTH{1'b0}};
         div_by_zero <= 1'b0;
      end else if (accept_s) begin
         op_r   <= op;
         cnt_r  <= {CNT_W{1'b0}};
         hi_r   <= {WIDTH{1'b0}};
         lo_r   <= op ? a : b;
         opnd_r <= op ? b : a;
         if (dbz_s) begin
            result_lo   <= {WIDTH{1'b1}};
            result_hi   <= a;
            div_by_zero <= 1'b1;
         end else begin
            div_by_zero <= 1'b0;
         end
      end else if (state_r == RUN) begin
         hi_r  <= hi_nxt_s;
         lo_r  <= lo_nxt_s;
         cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         if (cnt_r == CNT_W'(ITER - 1)) begin
            result_lo <= lo_nxt_s;
            result_hi <= hi_nxt_s;
         end
      end
   end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle unsigned 16-bit multiply/divide sequencer.
- Drives one internal ALU instance (16-bit add with carry-in `ci` and B-invert `nb`) over 16 iterations: shift-add for multiply, restoring divide for division.
- Sits beside the main datapath ALU and is started by the core's execute stage.
- Signals completion with a single-cycle `done` pulse.

Parameters:
- WIDTH, 16, operand width; the only supported value is 16, matching the ALU.
- ITER, 16, iteration count; must equal WIDTH.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only when not busy.
- op  input  1  0 = multiply, 1 = divide.
- a  input  16  multiplicand / dividend.
- b  input  16  multiplier / divisor.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse when results become valid.
- result_lo  output  16  product[15:0] / quotient.
- result_hi  output  16  product[31:16] / remainder.
- div_by_zero  output  1  set with `done` when op=1 and b=0; held until the next accepted start.

Behaviour:
- Interface clocking: one clock; reset is synchronous and active-high.
- Reset: state=IDLE; busy, done, div_by_zero, result_lo, result_hi, iteration counter and working registers all 0.
- Reset mid-operation aborts with no `done` and clears the results.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches a, b, op; counter=0; next state RUN.
  - Exception: op=1 and b=0 goes straight to DONE.
- RUN:
  - busy=1; one iteration per edge; counter increments.
  - After the 16th iteration (counter==15), next state DONE.
- DONE:
  - done=1 for exactly this one cycle; result registers are written on entry.
  - start=1 in DONE is accepted, giving back-to-back operation; otherwise next state IDLE.
- start during RUN is ignored. Operand changes during RUN have no effect.
- Latency: `done` is high in the cycle following the 17th rising edge after the edge that sampled start (16 RUN edges plus the transition edge).
- Divide-by-zero latency: `done` is high after the 1st edge.
- Outputs result_lo, result_hi and div_by_zero hold their values until the next operation completes or reset.
- Multiply (working regs: hi=0, lo=b, mcand=a):
  - ALU is driven with ci=0, nb=0, A=hi, B=(lo[0] ? mcand : 0).
  - Carry c = (A15&B15) | ((A15|B15)&~S15).
  - Update {hi,lo} <= {c, S, lo} >> 1.
  - Final product = {hi, lo}.
- Divide (working regs: rem=0, quo=a):
  - Shift {r17, quo} <= {rem, quo} << 1, with r17 17 bits wide.
  - ALU is driven with A=r17[15:0], B=b, ci=1, nb=1; carry c as above, with B replaced by ~b.
  - If r17[16] | c: rem=S and quo[0]=1; else rem=r17[15:0] and quo[0]=0.
  - Final result_lo=quo, result_hi=rem.
- Divide by zero: result_lo=16'hFFFF, result_hi=a, div_by_zero=1.
- All arithmetic is modulo 2^16 per ALU pass; the carry is derived internally because the ALU exposes no carry-out.

Test Plan:
- Multiply: op=0, a=300, b=500, start one cycle → busy high for 16 cycles, done pulse at edge 17, result_hi=16'h0002, result_lo=16'h49F0.
- Max multiply: a=16'hFFFF, b=16'hFFFF → result_hi=16'hFFFE, result_lo=16'h0001, div_by_zero=0.
- Divide: op=1, a=1000, b=7 → result_lo=142, result_hi=6. Also a=5, b=9 → quotient 0, remainder 5.
- Divide by zero: op=1, a=1234, b=0 → done after 1 edge, busy never high, result_lo=16'hFFFF, result_hi=1234, div_by_zero=1.
- Back-to-back and ignored start:
  - Assert start again at RUN cycle 5 with different operands → ignored; the first result is unchanged.
  - start in the DONE cycle → second op accepted; done pulses again 17 edges later.
- Reset mid-op: rst=1 for one edge at RUN cycle 8 → next cycle busy=0, done=0, results 0; no done pulse follows.
